// File: rtl/psum_acc.sv
// Partial-sum accumulator: sums acc_len signed beats with saturation and presents the result on a registered valid/ready port.
// Optional macro PSUM_ACC_RELU_EN clamps negative final results to zero.
module psum_acc #(
    parameter int psum_bw = 16,
    parameter int acc_len = 4,
    parameter int cnt_bw  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [psum_bw-1:0] in_psum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [psum_bw-1:0] out_psum,
    output logic               out_sat
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [cnt_bw-1:0] LAST_CNT = cnt_bw'(acc_len - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic        [cnt_bw-1:0]   r_cnt;
    logic signed [psum_bw-1:0]  r_acc;
    logic                       r_grp_sat;
    logic                       r_out_valid;
    logic        [psum_bw-1:0]  r_out_psum;
    logic                       r_out_sat;

    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_drain;
    logic                       w_first;
    logic                       w_last;
    logic                       w_final;
    logic signed [psum_bw:0]    w_sum;
    logic        [psum_bw-1:0]  w_acc_nxt;
    logic                       w_grp_nxt;

    // A (psum_bw+1)-bit sum overflows psum_bw exactly when its top two bits differ.
    function automatic logic f_ovf(input logic signed [psum_bw:0] s);
        f_ovf = s[psum_bw] ^ s[psum_bw-1];
    endfunction

    function automatic logic [psum_bw-1:0] f_clamp(input logic signed [psum_bw:0] s);
        if (s[psum_bw] != s[psum_bw-1]) begin
            f_clamp = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                 : {1'b0, {(psum_bw-1){1'b1}}};
        end else begin
            f_clamp = s[psum_bw-1:0];
        end
    endfunction

    function automatic logic [psum_bw-1:0] f_relu(input logic [psum_bw-1:0] v);
`ifdef PSUM_ACC_RELU_EN
        f_relu = v[psum_bw-1] ? '0 : v;
`else
        f_relu = v;
`endif
    endfunction

    // In HOLD the input stage only advances when the held result drains in the same cycle.
    assign w_in_ready = !clear && ((r_state == ST_ACC) || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_drain    = r_out_valid && out_ready && !clear;
    assign w_first    = (r_cnt == '0);
    assign w_last     = (r_cnt == LAST_CNT);
    assign w_final    = w_accept && w_last;

    assign w_sum      = {r_acc[psum_bw-1], r_acc} + {in_psum[psum_bw-1], in_psum};
    assign w_acc_nxt  = w_first ? in_psum : f_clamp(w_sum);
    assign w_grp_nxt  = w_first ? 1'b0 : (r_grp_sat | f_ovf(w_sum));

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_ACC;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_final) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_drain && !w_final) begin
                        w_state_nxt = ST_ACC;
                    end
                end
                default: w_state_nxt = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_grp_sat   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_psum  <= '0;
            r_out_sat   <= 1'b0;
        end else if (clear) begin
            // The held result value is left stale; only its qualifiers are dropped.
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc     <= w_acc_nxt;
                r_grp_sat <= w_grp_nxt;
                r_cnt     <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_final) begin
                r_out_psum  <= f_relu(w_acc_nxt);
                r_out_sat   <= w_grp_nxt;
                r_out_valid <= 1'b1;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_psum  = r_out_psum;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_psum_acc.sv
// Bench for psum_acc: directed scenarios plus randomized traffic against a group-sum reference model.
module tb_psum_acc;

    localparam int PB = 16;
    localparam int AL = 4;
    localparam int CB = 8;
`ifdef PSUM_ACC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [PB-1:0] in_psum;
    logic          out_valid;
    logic          out_ready;
    logic [PB-1:0] out_psum;
    logic          out_sat;

    int total = 0;
    int bad   = 0;

    int acc_beats[$];
    int got_psum[$];
    bit got_sat[$];
    int exp_p[$];
    bit exp_s[$];

    // Values sampled before the clock edge of the most recent tick.
    bit s_ir, s_ov, s_os;
    int s_op;

    always #5 clk = ~clk;

    psum_acc #(.psum_bw(PB), .acc_len(AL), .cnt_bw(CB)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_psum  (out_psum),
        .out_sat   (out_sat)
    );

    task automatic tick(input bit v, input int d, input bit ordy, input bit clr);
        @(negedge clk);
        in_valid  = v;
        in_psum   = d[PB-1:0];
        out_ready = ordy;
        clear     = clr;
        #1;
        s_ir = in_ready;
        s_ov = out_valid;
        s_os = out_sat;
        s_op = $signed(out_psum);
        if (in_valid && in_ready) acc_beats.push_back(d);
        if (out_valid && out_ready && !clr) begin
            got_psum.push_back($signed(out_psum));
            got_sat.push_back(out_sat);
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_psum = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        acc_beats.delete(); got_psum.delete(); got_sat.delete();
    endtask

    // Reference: each run of acc_len accepted beats forms one result, summed with clamping after every add.
    task automatic run_model();
        int acc;
        bit f;
        int n;
        exp_p.delete(); exp_s.delete();
        acc = 0; f = 1'b0; n = 0;
        foreach (acc_beats[i]) begin
            if (n == 0) begin
                acc = acc_beats[i];
                f = 1'b0;
            end else begin
                acc = acc + acc_beats[i];
                if (acc > 32767) begin acc = 32767; f = 1'b1; end
                else if (acc < -32768) begin acc = -32768; f = 1'b1; end
            end
            n++;
            if (n == AL) begin
                exp_p.push_back((RELU && acc < 0) ? 0 : acc);
                exp_s.push_back(f);
                n = 0;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (out_psum !== 16'h0000) begin bad++; $display("FAIL reset_out_psum got=%h want=0000", out_psum); end
        total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat got=%0b want=0", out_sat); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    endtask

    task automatic test_basic();
        int beats[4] = '{10, -3, 7, 2};
        bit dropped = 1'b0;
        bit early = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, beats[i], 1'b1, 1'b0);
            if (!s_ir) dropped = 1'b1;
            if (s_ov) early = 1'b1;
        end
        #2;
        total++; if (early !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=1 want=0"); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%0b want=1", out_valid); end
        total++; if ($signed(out_psum) !== 16) begin bad++; $display("FAIL basic_psum got=%0d want=16", $signed(out_psum)); end
        total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL basic_sat got=%0b want=0", out_sat); end
        tick(1'b0, 0, 1'b1, 1'b0);
        if (!s_ir) dropped = 1'b1;
        total++; if (dropped !== 1'b0) begin bad++; $display("FAIL basic_in_ready_drop got=1 want=0"); end
    endtask

    task automatic test_saturation();
        int beats[8] = '{30000, 30000, -5, 1, -32768, -1, 0, 0};
        int want2;
        want2 = RELU ? 0 : -32768;
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, beats[i], 1'b1, 1'b0);
        repeat (2) tick(1'b0, 0, 1'b1, 1'b0);
        total++;
        if (got_psum.size() !== 2) begin
            bad++; $display("FAIL sat_count got=%0d want=2", got_psum.size());
        end else begin
            total++; if (got_psum[0] !== 32763) begin bad++; $display("FAIL sat_pos_psum got=%0d want=32763", got_psum[0]); end
            total++; if (got_sat[0] !== 1'b1) begin bad++; $display("FAIL sat_pos_flag got=%0b want=1", got_sat[0]); end
            total++; if (got_psum[1] !== want2) begin bad++; $display("FAIL sat_neg_psum got=%0d want=%0d", got_psum[1], want2); end
            total++; if (got_sat[1] !== 1'b1) begin bad++; $display("FAIL sat_neg_flag got=%0b want=1", got_sat[1]); end
        end
    endtask

    task automatic test_backpressure();
        bit unstable = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 9, 1'b0, 1'b0);
            if (s_ir !== 1'b0 || s_ov !== 1'b1 || s_op !== 4 || s_os !== 1'b0) unstable = 1'b1;
        end
        total++; if (unstable !== 1'b0) begin bad++; $display("FAIL bp_hold_stable got=unstable want=stable"); end
        total++; if (acc_beats.size() !== 4) begin bad++; $display("FAIL bp_no_accept got=%0d want=4", acc_beats.size()); end
        tick(1'b1, 9, 1'b1, 1'b0);
        total++; if (s_ir !== 1'b1) begin bad++; $display("FAIL bp_passthru_ready got=%0b want=1", s_ir); end
        total++; if (acc_beats.size() !== 5) begin bad++; $display("FAIL bp_passthru_accept got=%0d want=5", acc_beats.size()); end
        total++; if (got_psum.size() !== 1 || got_psum[0] !== 4) begin bad++; $display("FAIL bp_drain got_n=%0d want=1 value 4", got_psum.size()); end
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_after_drain_valid got=%0b want=0", out_valid); end
    endtask

    task automatic test_relu();
        int beats[4] = '{-8, -1, -1, -1};
        int want;
        want = RELU ? 0 : -11;
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, beats[i], 1'b1, 1'b0);
        tick(1'b0, 0, 1'b1, 1'b0);
        total++;
        if (got_psum.size() !== 1) begin
            bad++; $display("FAIL relu_count got=%0d want=1", got_psum.size());
        end else begin
            total++; if (got_psum[0] !== want) begin bad++; $display("FAIL relu_psum got=%0d want=%0d", got_psum[0], want); end
            total++; if (got_sat[0] !== 1'b0) begin bad++; $display("FAIL relu_sat got=%0b want=0", got_sat[0]); end
        end
    endtask

    task automatic test_clear();
        do_reset();
        tick(1'b1, 5, 1'b1, 1'b0);
        tick(1'b1, 5, 1'b1, 1'b0);
        tick(1'b1, 5, 1'b1, 1'b1);
        total++; if (s_ir !== 1'b0) begin bad++; $display("FAIL clear_in_ready got=%0b want=0", s_ir); end
        for (int i = 0; i < 4; i++) tick(1'b1, 1, 1'b1, 1'b0);
        tick(1'b0, 0, 1'b1, 1'b0);
        total++; if (got_psum.size() !== 1 || got_psum[0] !== 4) begin bad++; $display("FAIL clear_group got_n=%0d want=1 value 4", got_psum.size()); end
        for (int i = 0; i < 4; i++) tick(1'b1, 1, 1'b0, 1'b0);
        #2;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clear_hold_setup got=%0b want=1", out_valid); end
        tick(1'b0, 0, 1'b0, 1'b1);
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clear_hold_valid got=%0b want=0", out_valid); end
        total++; if (out_psum !== 16'd4) begin bad++; $display("FAIL clear_stale_psum got=%0d want=4", out_psum); end
        total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL clear_sat got=%0b want=0", out_sat); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 7, 1'b1, 1'b0);
        tick(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 3, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%0b want=0", out_valid); end
        total++; if (out_psum !== 16'h0000) begin bad++; $display("FAIL areset_psum got=%0d want=0", out_psum); end
        #1;
        reset = 1'b0;
        acc_beats.delete(); got_psum.delete(); got_sat.delete();
        for (int i = 0; i < 4; i++) tick(1'b1, 2, 1'b1, 1'b0);
        tick(1'b0, 0, 1'b1, 1'b0);
        total++; if (got_psum.size() !== 1 || got_psum[0] !== 8) begin bad++; $display("FAIL areset_regroup got_n=%0d want=1 value 8", got_psum.size()); end
    endtask

    task automatic test_random();
        bit v, r;
        int d;
        bit p_ov, p_ordy;
        int p_op;
        bit p_os;
        int rule_err = 0;
        do_reset();
        p_ov = 1'b0; p_ordy = 1'b1; p_op = 0; p_os = 1'b0;
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(3) != 0);
            r = ($urandom_range(2) != 0);
            if ($urandom_range(1) != 0) d = int'($urandom_range(65535)) - 32768;
            else d = int'($urandom_range(200)) - 100;
            tick(v, d, r, 1'b0);
            if (s_ir !== (s_ov ? r : 1'b1)) rule_err++;
            if (p_ov && !p_ordy && (s_ov !== 1'b1 || s_op !== p_op || s_os !== p_os)) rule_err++;
            p_ov = s_ov; p_ordy = r; p_op = s_op; p_os = s_os;
        end
        repeat (3) tick(1'b0, 0, 1'b1, 1'b0);
        run_model();
        total++; if (rule_err !== 0) begin bad++; $display("FAIL rand_handshake_rules got=%0d want=0", rule_err); end
        total++;
        if (got_psum.size() !== exp_p.size()) begin
            bad++; $display("FAIL rand_count got=%0d want=%0d", got_psum.size(), exp_p.size());
        end else begin
            foreach (exp_p[i]) begin
                total++;
                if (got_psum[i] !== exp_p[i] || got_sat[i] !== exp_s[i]) begin
                    bad++;
                    $display("FAIL rand_result[%0d] got=%0d/%0b want=%0d/%0b", i, got_psum[i], got_sat[i], exp_p[i], exp_s[i]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_psum = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_relu();
        test_clear();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
